// File: rtl/signed_booth_mult.sv
// Sequential radix-2 Booth multiplier for two's-complement operands.
// A new multiplication starts on the rising edge of (Fx & Fy); the result is held until the next one.
module signed_booth_mult #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned COUNTER_WIDTH = 4
) (
  input  logic                      Clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     X_parallel,
  input  logic                      Fx,
  input  logic [DATA_WIDTH-1:0]     Y_parallel,
  input  logic                      Fy,
  output logic [2*DATA_WIDTH-1:0]   Product,
  output logic                      Fp,
  output logic                      Busy
);

  // One extra accumulator bit keeps A - M exact when M is the most negative operand.
  localparam int unsigned AccWidth = DATA_WIDTH + 1;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StCalc = 1'b1;

  logic [0:0]               state_q, state_d;
  logic [AccWidth-1:0]      a_q, a_d;
  logic [AccWidth-1:0]      m_q, m_d;
  logic [DATA_WIDTH-1:0]    q_q, q_d;
  logic                     qm1_q, qm1_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic                     both_rdy_q, both_rdy_d;
  logic [2*DATA_WIDTH-1:0]  product_q, product_d;
  logic                     fp_q, fp_d;
  logic                     busy_q, busy_d;

  logic                     start;
  logic                     last_iter;
  logic [AccWidth-1:0]      booth_sum;
  logic [AccWidth-1:0]      a_shift;
  logic [DATA_WIDTH-1:0]    q_shift;

  assign start     = Fx & Fy & ~both_rdy_q;
  assign last_iter = (cnt_q == COUNTER_WIDTH'(DATA_WIDTH - 1));

  // Booth recoding of {Q[0], Q_-1}, then arithmetic shift of {A, Q, Q_-1}.
  always_comb begin
    booth_sum = a_q;
    unique case ({q_q[0], qm1_q})
      2'b01:   booth_sum = a_q + m_q;
      2'b10:   booth_sum = a_q - m_q;
      default: booth_sum = a_q;
    endcase
    a_shift = {booth_sum[AccWidth-1], booth_sum[AccWidth-1:1]};
    q_shift = {booth_sum[0], q_q[DATA_WIDTH-1:1]};
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    m_d        = m_q;
    q_d        = q_q;
    qm1_d      = qm1_q;
    cnt_d      = cnt_q;
    product_d  = product_q;
    fp_d       = fp_q;
    busy_d     = busy_q;
    both_rdy_d = Fx & Fy;

    case (state_q)
      StIdle: begin
        if (start) begin
          m_d     = {X_parallel[DATA_WIDTH-1], X_parallel};
          q_d     = Y_parallel;
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          fp_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = StCalc;
        end
      end
      StCalc: begin
        a_d   = a_shift;
        q_d   = q_shift;
        qm1_d = q_q[0];
        cnt_d = cnt_q + COUNTER_WIDTH'(1);
        if (last_iter) begin
          product_d = {a_shift[DATA_WIDTH-1:0], q_shift};
          fp_d      = 1'b1;
          busy_d    = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      a_q        <= '0;
      m_q        <= '0;
      q_q        <= '0;
      qm1_q      <= 1'b0;
      cnt_q      <= '0;
      both_rdy_q <= 1'b0;
      product_q  <= '0;
      fp_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      m_q        <= m_d;
      q_q        <= q_d;
      qm1_q      <= qm1_d;
      cnt_q      <= cnt_d;
      both_rdy_q <= both_rdy_d;
      product_q  <= product_d;
      fp_q       <= fp_d;
      busy_q     <= busy_d;
    end
  end

  assign Product = product_q;
  assign Fp      = fp_q;
  assign Busy    = busy_q;

endmodule

// File: tb/tb_signed_booth_mult.sv
// Directed bench for signed_booth_mult (DATA_WIDTH=8); expected products are hand-computed.
module tb_signed_booth_mult;

  logic        Clk;
  logic        reset;
  logic [7:0]  X_parallel;
  logic        Fx;
  logic [7:0]  Y_parallel;
  logic        Fy;
  logic [15:0] Product;
  logic        Fp;
  logic        Busy;

  int errors = 0;
  int checks = 0;

  signed_booth_mult #(
    .DATA_WIDTH    (8),
    .COUNTER_WIDTH (4)
  ) dut (
    .Clk        (Clk),
    .reset      (reset),
    .X_parallel (X_parallel),
    .Fx         (Fx),
    .Y_parallel (Y_parallel),
    .Fy         (Fy),
    .Product    (Product),
    .Fp         (Fp),
    .Busy       (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One rising edge; inputs are driven and outputs sampled at the falling edge.
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drop the flags for one edge, then raise both together; the start edge is the next posedge.
  // Checks Busy through all 8 iterations and the result on the 8th edge after start.
  task automatic run_mult(input string tag, input logic [7:0] x, input logic [7:0] y,
                          input logic [15:0] exp);
    int busy_bad;
    Fx = 1'b0;
    Fy = 1'b0;
    step();
    X_parallel = x;
    Y_parallel = y;
    Fx = 1'b1;
    Fy = 1'b1;
    step();
    busy_bad = 0;
    for (int i = 1; i < 8; i++) begin
      if (Busy !== 1'b1 || Fp !== 1'b0) busy_bad++;
      step();
    end
    if (Busy !== 1'b1 || Fp !== 1'b0) busy_bad++;
    check({tag, "_busy_window"}, busy_bad, 0);
    step();
    check({tag, "_product"}, Product, exp);
    check({tag, "_fp"}, Fp, 1'b1);
    check({tag, "_busy_done"}, Busy, 1'b0);
  endtask

  initial begin
    int busy_seen;
    int bad;
    reset      = 1'b0;
    X_parallel = '0;
    Y_parallel = '0;
    Fx         = 1'b0;
    Fy         = 1'b0;
    @(negedge Clk);
    step();
    step();
    check("reset_product", Product, 16'h0000);
    check("reset_fp", Fp, 1'b0);
    check("reset_busy", Busy, 1'b0);

    reset = 1'b1;
    step();
    check("idle_no_start", Busy, 1'b0);

    run_mult("p3x5", 8'd3, 8'd5, 16'h000F);
    run_mult("m3x5", 8'hFD, 8'd5, 16'hFFF1);
    run_mult("p5xm3", 8'd5, 8'hFD, 16'hFFF1);
    run_mult("m128xm128", 8'h80, 8'h80, 16'h4000);
    run_mult("p127xm128", 8'h7F, 8'h80, 16'hC080);
    run_mult("m1xm1", 8'hFF, 8'hFF, 16'h0001);
    run_mult("zero", 8'h00, 8'h9C, 16'h0000);

    // Sticky-high flags with changing operands: no second multiplication.
    busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      X_parallel = 8'(i);
      Y_parallel = 8'(3 * i);
      step();
      if (Busy !== 1'b0) busy_seen++;
    end
    check("sticky_busy", busy_seen, 0);
    check("sticky_fp", Fp, 1'b1);
    check("sticky_product", Product, 16'h0000);

    // Operand changes and a flag re-toggle during CALC are ignored.
    Fx = 1'b0;
    Fy = 1'b0;
    step();
    X_parallel = 8'd127;
    Y_parallel = 8'd127;
    Fx = 1'b1;
    Fy = 1'b1;
    step();
    X_parallel = 8'h55;
    Y_parallel = 8'hAA;
    Fx = 1'b0;
    step();
    Fx = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("ignore_busy_mid", Busy, 1'b1);
    step();
    check("ignore_product", Product, 16'h3F01);
    check("ignore_fp", Fp, 1'b1);
    busy_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (Busy !== 1'b0) busy_seen++;
    end
    check("ignore_not_queued", busy_seen, 0);
    check("ignore_product_held", Product, 16'h3F01);

    // Reset in the middle of CALC, flags held high across release.
    Fx = 1'b0;
    Fy = 1'b0;
    step();
    X_parallel = 8'd9;
    Y_parallel = 8'd9;
    Fx = 1'b1;
    Fy = 1'b1;
    step();
    for (int i = 0; i < 4; i++) step();
    check("midreset_busy_before", Busy, 1'b1);
    reset = 1'b0;
    step();
    check("midreset_product", Product, 16'h0000);
    check("midreset_fp", Fp, 1'b0);
    check("midreset_busy", Busy, 1'b0);
    X_parallel = 8'hF9;
    Y_parallel = 8'd9;
    reset = 1'b1;
    step();
    check("release_start", Busy, 1'b1);
    for (int i = 0; i < 7; i++) step();
    check("release_fp_low", Fp, 1'b0);
    step();
    check("release_product", Product, 16'hFFC1);
    check("release_fp", Fp, 1'b1);

    // Flags rise on different cycles: Fx before edge 2, Fy before edge 6.
    Fx = 1'b0;
    Fy = 1'b0;
    X_parallel = 8'hFF;
    Y_parallel = 8'hFF;
    step();
    bad = 0;
    for (int e = 1; e <= 16; e++) begin
      Fx = (e >= 2);
      Fy = (e >= 6);
      step();
      if (Busy !== ((e >= 6 && e <= 13) ? 1'b1 : 1'b0)) bad++;
      if (Fp !== ((e < 6 || e >= 14) ? 1'b1 : 1'b0)) bad++;
    end
    check("staggered_timing", bad, 0);
    check("staggered_product", Product, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
